// File: rtl/led_ring_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_ring_decoder_pkg
// Description : Shared geometry, legal frame constants and types for the
//               LED ring decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package led_ring_decoder_pkg;

    localparam int LED_ROWS = 3;
    localparam int LED_COLS = 4;
    localparam int LED_BITS = LED_ROWS * LED_COLS;

    // Bit index r*LED_COLS+c; each ring position lights two adjacent LEDs.
    localparam logic [LED_BITS-1:0] c_frame_s0 = 12'h011;
    localparam logic [LED_BITS-1:0] c_frame_s1 = 12'h022;
    localparam logic [LED_BITS-1:0] c_frame_s2 = 12'h044;
    localparam logic [LED_BITS-1:0] c_frame_s3 = 12'h088;
    localparam logic [LED_BITS-1:0] c_frame_s4 = 12'h880;
    localparam logic [LED_BITS-1:0] c_frame_s5 = 12'h440;
    localparam logic [LED_BITS-1:0] c_frame_s6 = 12'h220;
    localparam logic [LED_BITS-1:0] c_frame_s7 = 12'h110;

    typedef logic [2:0] ring_state_t;

    typedef enum logic [0:0] {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } fsm_t;

    function automatic ring_state_t ring_delta(input ring_state_t from_st,
                                               input ring_state_t to_st);
        return ring_state_t'(to_st - from_st);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_ring_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : led_ring_decoder_if
// Description : Frame input stream and step output stream of the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_ring_decoder_if;
    import led_ring_decoder_pkg::*;

    logic                pat_valid;
    logic [LED_BITS-1:0] pat;
    logic                pat_ready;
    logic                out_valid;
    logic                out_ready;
    logic                dir_bit;

    modport master (
        output pat_valid, pat, out_ready,
        input  pat_ready, out_valid, dir_bit
    );

    modport slave (
        input  pat_valid, pat, out_ready,
        output pat_ready, out_valid, dir_bit
    );

endinterface
`default_nettype wire

// File: rtl/led_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_decode
// Description : Combinational map of an LED frame to {legal, ring state}.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_decode
    import led_ring_decoder_pkg::*;
(
    input  wire logic [LED_BITS-1:0] pat,
    output      logic                legal,
    output      ring_state_t         dec_state
);

    always_comb begin
        legal     = 1'b1;
        dec_state = 3'd0;
        unique case (pat)
            c_frame_s0: dec_state = 3'd0;
            c_frame_s1: dec_state = 3'd1;
            c_frame_s2: dec_state = 3'd2;
            c_frame_s3: dec_state = 3'd3;
            c_frame_s4: dec_state = 3'd4;
            c_frame_s5: dec_state = 3'd5;
            c_frame_s6: dec_state = 3'd6;
            c_frame_s7: dec_state = 3'd7;
            default:    legal     = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/led_ring_decoder.sv
`default_nettype none
// ============================================================================
// Module      : led_ring_decoder
// Description : Recovers direction bits from a sampled 8-position LED ring.
// Revision    : 1.0 - initial release
// ============================================================================
module led_ring_decoder
    import led_ring_decoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    led_ring_decoder_if.slave     bus,
    output      logic [2:0]       state,
    output      logic             synced,
    output      logic             err,
    output      logic [CNT_W-1:0] step_cnt,
    output      logic [CNT_W-1:0] err_cnt
);

    fsm_t             r_fsm, w_fsm_nxt;
    ring_state_t      r_state, w_state_nxt;
    logic             r_out_valid, r_dir_bit, r_err;
    logic [CNT_W-1:0] r_step_cnt, r_err_cnt;

    logic             w_legal, w_accept, w_emit, w_dir, w_err;
    ring_state_t      w_dec_state, w_delta;

    led_pattern_decode u_decode (
        .pat       (bus.pat),
        .legal     (w_legal),
        .dec_state (w_dec_state)
    );

    assign bus.pat_ready = !r_out_valid || bus.out_ready;
    assign w_accept      = bus.pat_valid && bus.pat_ready;
    assign w_delta       = ring_delta(r_state, w_dec_state);

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_dir       = 1'b0;
        w_err       = 1'b0;
        if (w_accept) begin
            if (!w_legal) begin
                w_err     = 1'b1;
                w_fsm_nxt = UNSYNC;
            end else if (r_fsm == UNSYNC) begin
                w_state_nxt = w_dec_state;
                w_fsm_nxt   = SYNC;
            end else begin
                unique case (w_delta)
                    3'd0: ;  // repeated frame: nothing moves
                    3'd1: begin
                        w_emit      = 1'b1;
                        w_dir       = 1'b1;
                        w_state_nxt = w_dec_state;
                    end
                    3'd7: begin
                        w_emit      = 1'b1;
                        w_state_nxt = w_dec_state;
                    end
                    default: begin
                        w_err       = 1'b1;
                        w_state_nxt = w_dec_state;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= UNSYNC;
            r_state     <= 3'd0;
            r_out_valid <= 1'b0;
            r_dir_bit   <= 1'b0;
            r_err       <= 1'b0;
            r_step_cnt  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            r_err   <= w_err;
            // An accept implies the buffer is empty or draining this cycle.
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_dir_bit   <= w_dir;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_emit && (r_step_cnt != {CNT_W{1'b1}}))
                r_step_cnt <= r_step_cnt + 1'b1;
            if (w_err && (r_err_cnt != {CNT_W{1'b1}}))
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.dir_bit   = r_dir_bit;
    assign state         = r_state;
    assign synced        = (r_fsm == SYNC);
    assign err           = r_err;
    assign step_cnt      = r_step_cnt;
    assign err_cnt       = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_led_ring_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_ring_decoder
// Description : Directed self-checking bench for led_ring_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_ring_decoder;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [2:0]       state;
    logic             synced;
    logic             err;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] err_cnt;

    int n_checks;
    int n_pass;

    logic [11:0] c_frames [8];

    led_ring_decoder_if bus_if ();

    led_ring_decoder #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .state    (state),
        .synced   (synced),
        .err      (err),
        .step_cnt (step_cnt),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus_if.pat_valid = 1'b0;
        bus_if.pat       = 12'h000;
        bus_if.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One accepted frame; outputs checked afterwards reflect its processing.
    task automatic send(input logic [11:0] frame);
        bus_if.pat_valid = 1'b1;
        bus_if.pat       = frame;
        tick();
        bus_if.pat_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},     32'(state),            32'd0);
        chk({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd0);
        chk({tag, "_dir"},       32'(bus_if.dir_bit),   32'd0);
        chk({tag, "_err"},       32'(err),              32'd0);
        chk({tag, "_synced"},    32'(synced),           32'd0);
        chk({tag, "_step_cnt"},  32'(step_cnt),         32'd0);
        chk({tag, "_err_cnt"},   32'(err_cnt),          32'd0);
        chk({tag, "_pat_ready"}, 32'(bus_if.pat_ready), 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        c_frames  = '{12'h011, 12'h022, 12'h044, 12'h088,
                      12'h880, 12'h440, 12'h220, 12'h110};
        rst              = 1'b1;
        bus_if.pat_valid = 1'b0;
        bus_if.pat       = 12'h000;
        bus_if.out_ready = 1'b1;
        tick();

        // Reset state and four anticlockwise steps
        do_reset();
        chk_reset_vals("rst");
        send(12'h011);
        chk("sync_synced", 32'(synced), 32'd1);
        chk("sync_no_step", 32'(bus_if.out_valid), 32'd0);
        send(12'h022);
        chk("step1_valid", 32'(bus_if.out_valid), 32'd1);
        chk("step1_dir", 32'(bus_if.dir_bit), 32'd1);
        send(12'h044);
        send(12'h088);
        send(12'h880);
        chk("ccw_dir", 32'(bus_if.dir_bit), 32'd1);
        chk("ccw_state", 32'(state), 32'd4);
        chk("ccw_step_cnt", 32'(step_cnt), 32'd4);
        tick();
        chk("ccw_drained", 32'(bus_if.out_valid), 32'd0);

        // Wrap-around both ways
        do_reset();
        send(12'h110);
        chk("wrap_sync_state", 32'(state), 32'd7);
        send(12'h011);
        chk("wrap_70_valid", 32'(bus_if.out_valid), 32'd1);
        chk("wrap_70_dir", 32'(bus_if.dir_bit), 32'd1);
        chk("wrap_70_state", 32'(state), 32'd0);
        send(12'h110);
        chk("wrap_07_valid", 32'(bus_if.out_valid), 32'd1);
        chk("wrap_07_dir", 32'(bus_if.dir_bit), 32'd0);
        chk("wrap_07_state", 32'(state), 32'd7);
        chk("wrap_err_cnt", 32'(err_cnt), 32'd0);
        chk("wrap_step_cnt", 32'(step_cnt), 32'd2);

        // Skipped position
        do_reset();
        send(12'h011);
        send(12'h044);
        chk("skip_err", 32'(err), 32'd1);
        chk("skip_state", 32'(state), 32'd2);
        chk("skip_no_valid", 32'(bus_if.out_valid), 32'd0);
        chk("skip_synced", 32'(synced), 32'd1);
        chk("skip_err_cnt", 32'(err_cnt), 32'd1);
        tick();
        chk("skip_err_pulse", 32'(err), 32'd0);
        send(12'h088);
        chk("skip_next_valid", 32'(bus_if.out_valid), 32'd1);
        chk("skip_next_dir", 32'(bus_if.dir_bit), 32'd1);
        chk("skip_next_state", 32'(state), 32'd3);

        // Illegal frame, resync, repeated frame
        do_reset();
        send(12'h011);
        send(12'h033);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_synced", 32'(synced), 32'd0);
        chk("ill_state", 32'(state), 32'd0);
        send(12'h022);
        chk("resync_synced", 32'(synced), 32'd1);
        chk("resync_no_step", 32'(bus_if.out_valid), 32'd0);
        chk("resync_state", 32'(state), 32'd1);
        chk("resync_err", 32'(err), 32'd0);
        send(12'h022);
        chk("rep_no_step", 32'(bus_if.out_valid), 32'd0);
        chk("rep_no_err", 32'(err), 32'd0);
        chk("rep_step_cnt", 32'(step_cnt), 32'd0);
        chk("rep_err_cnt", 32'(err_cnt), 32'd1);

        // Backpressure then same-cycle drain and accept
        do_reset();
        bus_if.out_ready = 1'b0;
        send(12'h011);
        send(12'h022);
        chk("bp_valid", 32'(bus_if.out_valid), 32'd1);
        bus_if.pat_valid = 1'b1;
        bus_if.pat       = 12'h011;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_ready_%0d", i), 32'(bus_if.pat_ready), 32'd0);
            tick();
            chk($sformatf("bp_dir_%0d", i), 32'(bus_if.dir_bit), 32'd1);
            chk($sformatf("bp_hold_%0d", i), 32'(bus_if.out_valid), 32'd1);
            chk($sformatf("bp_state_%0d", i), 32'(state), 32'd1);
        end
        bus_if.out_ready = 1'b1;
        #1;
        chk("rel_ready", 32'(bus_if.pat_ready), 32'd1);
        tick();
        bus_if.pat_valid = 1'b0;
        chk("rel_valid", 32'(bus_if.out_valid), 32'd1);
        chk("rel_dir", 32'(bus_if.dir_bit), 32'd0);
        chk("rel_state", 32'(state), 32'd0);
        chk("rel_step_cnt", 32'(step_cnt), 32'd2);
        send(12'h011);
        chk("drain_noemit_valid", 32'(bus_if.out_valid), 32'd0);

        // Reset while a step is pending and a frame is offered
        do_reset();
        bus_if.out_ready = 1'b0;
        send(12'h011);
        send(12'h022);
        chk("prerst_valid", 32'(bus_if.out_valid), 32'd1);
        rst              = 1'b1;
        bus_if.pat_valid = 1'b1;
        bus_if.pat       = 12'h044;
        tick();
        rst              = 1'b0;
        bus_if.pat_valid = 1'b0;
        bus_if.out_ready = 1'b1;
        #1;
        chk_reset_vals("rstpend");

        // Counter saturation
        do_reset();
        send(12'h011);
        for (int i = 1; i <= 260; i++) send(c_frames[i % 8]);
        chk("sat_step_cnt", 32'(step_cnt), 32'd255);
        chk("sat_state", 32'(state), 32'd4);
        for (int i = 0; i < 260; i++) send(12'h000);
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);
        chk("sat_step_keep", 32'(step_cnt), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_ring_decoder.md
LED_RING_DECODER -- requirements
Module: led_ring_decoder

Interface
REQ-001 Parameter CNT_W, default 8, width of the step and error counters.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pat_valid  input  1  pat carries a sampled LED frame.
REQ-005 pat  input  12  LED frame; bit index r*4+c, r=0 top row, c=0 leftmost column, 1 = lit.
REQ-006 pat_ready  output  1  frame accepted on a cycle when pat_valid && pat_ready.
REQ-007 out_valid  output  1  dir_bit/state hold a decoded step.
REQ-008 out_ready  input  1  consumer takes the step when out_valid && out_ready.
REQ-009 dir_bit  output  1  recovered input bit: 1 = state+1 (anticlockwise), 0 = state-1 (clockwise).
REQ-010 state  output  3  last legally decoded ring state 0..7.
REQ-011 synced  output  1  a reference state is held.
REQ-012 err  output  1  one-cycle pulse per rejected frame.
REQ-013 step_cnt, err_cnt  output  CNT_W  saturating counts of emitted steps and errors.

Function
REQ-014 Legal frames, exactly two lit bits: s0=12'h011, s1=12'h022, s2=12'h044, s3=12'h088, s4=12'h880, s5=12'h440, s6=12'h220, s7=12'h110; every other value is illegal.
REQ-015 FSM states UNSYNC and SYNC; a frame is processed only on the cycle it is accepted.
REQ-016 UNSYNC + legal frame: state <= decoded value, go to SYNC, no output step.
REQ-017 SYNC + legal frame: delta = (new - state) mod 8, 3-bit wrap arithmetic.
REQ-018 delta=1: emit step with dir_bit=1; delta=7: emit dir_bit=0; state <= new in both cases.
REQ-019 delta=0: frame discarded, no step, no err (repeated frame).
REQ-020 delta in 2..6: err pulse, state <= new, stay SYNC, no step.
REQ-021 Illegal frame in any FSM state: err pulse, state unchanged, go to UNSYNC.
REQ-022 Wrap-around: 7->0 is dir_bit=1; 0->7 is dir_bit=0.
REQ-023 Emitted step: out_valid and dir_bit registered, asserted the cycle after acceptance.
REQ-024 out_valid and dir_bit hold stable until out_ready; one-entry output buffer.
REQ-025 pat_ready = !out_valid || out_ready, combinational, so back-to-back steps run at full rate.
REQ-026 Same-cycle drain and accept: the buffer is replaced by the new step, or cleared if the frame emits none.
REQ-027 step_cnt increments per emitted step; err_cnt increments per err pulse; both saturate at 2^CNT_W-1.
REQ-028 synced = (FSM == SYNC); state output is the internal state register.

Reset
REQ-029 rst wins over every other input in the same cycle; FSM=UNSYNC.
REQ-030 Outputs on reset: state=0, out_valid=0, dir_bit=0, err=0, synced=0, step_cnt=0, err_cnt=0.
REQ-031 Reset while out_valid=1 drops the pending step without a handshake.
REQ-032 pat_ready=1 in the first cycle after reset.

Structure
REQ-033 A shared package holds LED_ROWS=3, LED_COLS=4, the 8 legal frame constants, the 3-bit state type and the FSM enum.
REQ-034 A combinational sub-module led_pattern_decode maps pat to {legal, state[2:0]}; all sequencing stays in led_ring_decoder.

Verification
REQ-035 Reset, frames 011, 022, 044, 088, 880 -> synced after the first frame; four steps dir_bit=1; state=4; step_cnt=4.
REQ-036 Sync on 110 (s7), then 011 (s0), then 110 (s7) -> dir_bit 1 then 0; err_cnt=0.
REQ-037 Sync on 011, then 044 (delta 2) -> err pulse, state=2, no out_valid; then 088 -> dir_bit=1.
REQ-038 Frames 011 then 033 (illegal) -> err pulse, synced=0, state=0; then 022 resyncs with no step.
REQ-039 Hold out_ready=0 after a step -> pat_ready=0 and dir_bit stable for 5 cycles; on release, a same-cycle accept emits the next step.
REQ-040 Assert rst while out_valid=1 and pat_valid=1 -> next cycle all outputs at reset values, frame ignored.
